dmem_arbiter: RTL

- Shares the single data_memory port between two requesters: port 0 (processor load/store datapath) and port 1 (serial boot/debug loader that writes program data).
- Grants one access per cycle.
- Enforces a bounded-burst round-robin policy.
- Tracks one-cycle read latency to route read returns to the requester that issued the read.
- Rejects misaligned or illegal-size accesses before they reach memory.
- Drives the processor stall signal.

---
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Bounded-burst round-robin arbiter sharing data_memory between the
//            processor datapath (port 0) and the boot/debug loader (port 1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    size0,
    input  logic [1:0]    size1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          stall0,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_size,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              c_CW       = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [c_CW-1:0] c_MAX      = c_CW'(MAX_BURST);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic [1:0]      c_OWN_NONE = 2'd0;
    localparam logic [1:0]      c_OWN_P0   = 2'd1;
    localparam logic [1:0]      c_OWN_P1   = 2'd2;

    logic [1:0]      r_owner;
    logic            r_last;       // 1 = port 1 was granted last
    logic [c_CW-1:0] r_cnt;
    logic            r_pend_valid;
    logic            r_pend_port;
    logic            r_pend_rd;
    logic            r_pend_err;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt_any;
    logic            w_legal0;
    logic            w_legal1;
    logic            w_sel_we;
    logic            w_sel_legal;
    logic [1:0]      w_gnt_owner;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic [1:0]      w_mem_size;
    logic            w_mem_re;
    logic            w_mem_we;
    logic            w_rvalid0;
    logic            w_rvalid1;

    function automatic logic f_legal(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b00:   f_legal = 1'b1;
            2'b01:   f_legal = ~lsb[0];
            2'b11:   f_legal = (lsb == 2'b00);
            default: f_legal = 1'b0;
        endcase
    endfunction

    assign w_legal0 = f_legal(size0, addr0[1:0]);
    assign w_legal1 = f_legal(size1, addr1[1:0]);

    // Reset gates the grant so nothing reaches memory while reset is high.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (r_owner == c_OWN_P0 && r_cnt < c_MAX) begin
                    w_gnt0 = 1'b1;
                end else if (r_owner == c_OWN_P1 && r_cnt < c_MAX) begin
                    w_gnt1 = 1'b1;
                end else if (r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end
        end
    end

    assign w_gnt_any   = w_gnt0 | w_gnt1;
    assign w_gnt_owner = w_gnt1 ? c_OWN_P1 : c_OWN_P0;

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_size  = 2'b00;
        w_sel_we    = 1'b0;
        w_sel_legal = 1'b0;
        if (w_gnt0) begin
            w_mem_addr  = addr0;
            w_mem_wdata = wdata0;
            w_mem_size  = size0;
            w_sel_we    = we0;
            w_sel_legal = w_legal0;
        end else if (w_gnt1) begin
            w_mem_addr  = addr1;
            w_mem_wdata = wdata1;
            w_mem_size  = size1;
            w_sel_we    = we1;
            w_sel_legal = w_legal1;
        end
    end

    // Illegal accesses keep their slot but never strobe the memory.
    assign w_mem_re = w_gnt_any & ~w_sel_we & w_sel_legal;
    assign w_mem_we = w_gnt_any &  w_sel_we & w_sel_legal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= c_OWN_NONE;
            r_last       <= 1'b1;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_port  <= 1'b0;
            r_pend_rd    <= 1'b0;
            r_pend_err   <= 1'b0;
        end else if (w_gnt_any) begin
            if (r_owner == w_gnt_owner) begin
                r_cnt <= (r_cnt == c_MAX) ? r_cnt : r_cnt + c_ONE;
            end else begin
                r_owner <= w_gnt_owner;
                r_cnt   <= c_ONE;
            end
            r_last       <= w_gnt1;
            r_pend_valid <= 1'b1;
            r_pend_port  <= w_gnt1;
            r_pend_rd    <= ~w_sel_we & w_sel_legal;
            r_pend_err   <= ~w_sel_legal;
        end else begin
            r_owner      <= c_OWN_NONE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
        end
    end

    // Completions are suppressed combinationally during reset so a return
    // owed to the reset cycle is dropped rather than delivered.
    assign w_rvalid0 = ~reset & r_pend_valid & ~r_pend_port;
    assign w_rvalid1 = ~reset & r_pend_valid &  r_pend_port;

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign stall0    = ~reset & req0 & ~w_gnt0;
    assign rvalid0   = w_rvalid0;
    assign rvalid1   = w_rvalid1;
    assign err0      = w_rvalid0 & r_pend_err;
    assign err1      = w_rvalid1 & r_pend_err;
    assign rdata0    = (w_rvalid0 & r_pend_rd) ? mem_rdata : '0;
    assign rdata1    = (w_rvalid1 & r_pend_rd) ? mem_rdata : '0;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign mem_size  = w_mem_size;
    assign mem_re    = w_mem_re;
    assign mem_we    = w_mem_we;

endmodule
`default_nettype wire
